// File: rtl/fp16_div_pkg.sv
// Shared constants and types for the half-precision divide scheduler.
// Pure definitions: no logic, no latency.
// No backpressure here; consumers are fp16_div_sched and fp16_mant_div.
package fp16_div_pkg;

    localparam int EXP_W    = 5;
    localparam int MAN_W    = 10;
    localparam int BIAS     = 15;
    localparam int QUO_BITS = 12;

    // Canonical quiet NaN and the all-ones exponent used for inf/NaN.
    localparam logic [15:0]      CANON_NAN = 16'h7E00;
    localparam logic [EXP_W-1:0] EXP_INF   = 5'h1F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/fp16_mant_div.sv
// Restoring divider for two 11-bit mantissas {1,frac}, one quotient bit per cycle.
// Latency: start loads operands; done rises 12 edges later and stays high until the next start.
// No backpressure: the caller holds q until it has consumed it.
// Ports: clk, reset (sync, active-high), start, dividend[10:0], divisor[10:0] -> done, q[11:0]
// (q[11] is the integer bit, q[10:0] the fraction; the remainder is discarded).
module fp16_mant_div
    import fp16_div_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [MAN_W:0]      dividend,
    input  logic [MAN_W:0]      divisor,
    output logic                done,
    output logic [QUO_BITS-1:0] q
);

    localparam int REM_W = MAN_W + 2;
    localparam int CNT_W = $clog2(QUO_BITS);

    logic [REM_W-1:0]    rem_q, rem_d;
    logic [MAN_W:0]      dvs_q, dvs_d;
    logic [QUO_BITS-1:0] quo_q, quo_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                run_q, run_d;
    logic                done_q, done_d;

    logic [REM_W:0]      diff;
    logic                fits;
    logic [REM_W-1:0]    rem_sel;

    always_comb begin
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        done_d  = done_q;
        // Trial subtraction; the borrow bit says whether the divisor fits.
        diff    = {1'b0, rem_q} - {2'b00, dvs_q};
        fits    = ~diff[REM_W];
        rem_sel = fits ? diff[REM_W-1:0] : rem_q;

        if (start) begin
            // Dividend < 2*divisor always holds for normalised mantissas,
            // so the first step yields the integer bit directly.
            rem_d  = {1'b0, dividend};
            dvs_d  = divisor;
            quo_d  = '0;
            cnt_d  = '0;
            run_d  = 1'b1;
            done_d = 1'b0;
        end else if (run_q) begin
            rem_d = rem_sel << 1;
            quo_d = {quo_q[QUO_BITS-2:0], fits};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(QUO_BITS - 1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q  <= '0;
            dvs_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign q    = quo_q;

endmodule

// File: rtl/fp16_div_sched.sv
// Two-requester round-robin scheduler around one IEEE-half divider (truncating).
// Latency: res_valid rises 14 edges after accept (1 edge for special operands when enabled).
// Backpressure: one op in flight; req ready low outside IDLE, result held until res_ready.
// Ports: clk, reset (sync, active-high); req{0,1}_valid/_ready/_a/_b operand pairs;
// res_valid/res_ready/res_d/res_id/res_ovf/res_unf result; busy = not IDLE.
// Optional: FP16_DIV_SPECIAL_EN decodes zero/inf/NaN operands and bypasses the divider.
module fp16_div_sched
    import fp16_div_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_d,
    output logic        res_id,
    output logic        res_ovf,
    output logic        res_unf,
    output logic        busy
);

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               sign_q, sign_d;
    logic signed [6:0]  exp_q, exp_d;
    logic [15:0]        res_dat_q, res_dat_d;
    logic               res_id_q, res_id_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;

    logic               gnt0, gnt1, accept;
    logic [15:0]        op_a, op_b;
    logic               op_sign;
    logic [EXP_W-1:0]   ea, eb;
    logic signed [6:0]  exp_diff;
    logic               div_start, div_done;
    logic [QUO_BITS-1:0] quo;
    logic signed [6:0]  exp_n;
    logic [MAN_W-1:0]   man_n;
    logic               sp_hit, sp_ovf, sp_unf;
    logic [15:0]        sp_res;

    // Round robin: on contention the requester not served last wins.
    assign gnt0       = req0_valid & (~req1_valid | last_grant_q);
    assign gnt1       = req1_valid & (~req0_valid | ~last_grant_q);
    assign req0_ready = (state_q == IDLE) & ~reset & gnt0;
    assign req1_ready = (state_q == IDLE) & ~reset & gnt1;
    assign accept     = req0_ready | req1_ready;

    assign op_a     = gnt1 ? req1_a : req0_a;
    assign op_b     = gnt1 ? req1_b : req0_b;
    assign op_sign  = op_a[15] ^ op_b[15];
    assign ea       = op_a[14:10];
    assign eb       = op_b[14:10];
    assign exp_diff = $signed({2'b00, ea}) - $signed({2'b00, eb}) + $signed(7'(BIAS));

`ifdef FP16_DIV_SPECIAL_EN
    logic a_zero, b_zero, a_top, b_top, a_nan, b_nan, a_inf, b_inf;

    // Exponent field 0 is flushed to zero, so subnormals never reach the divider.
    always_comb begin
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_top  = (ea == EXP_INF);
        b_top  = (eb == EXP_INF);
        a_nan  = a_top & (|op_a[MAN_W-1:0]);
        b_nan  = b_top & (|op_b[MAN_W-1:0]);
        a_inf  = a_top & ~(|op_a[MAN_W-1:0]);
        b_inf  = b_top & ~(|op_b[MAN_W-1:0]);
        sp_hit = a_zero | b_zero | a_top | b_top;
        sp_ovf = 1'b0;
        sp_unf = 1'b0;
        if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
            sp_res = CANON_NAN;
        end else if (b_zero | a_inf) begin
            sp_res = {op_sign, EXP_INF, {MAN_W{1'b0}}};
            sp_ovf = 1'b1;
        end else begin
            sp_res = {op_sign, {(EXP_W + MAN_W){1'b0}}};
            sp_unf = 1'b1;
        end
    end
`else
    assign sp_hit = 1'b0;
    assign sp_ovf = 1'b0;
    assign sp_unf = 1'b0;
    assign sp_res = '0;
`endif

    assign div_start = accept & ~sp_hit;

    fp16_mant_div u_mant_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend ({1'b1, op_a[MAN_W-1:0]}),
        .divisor  ({1'b1, op_b[MAN_W-1:0]}),
        .done     (div_done),
        .q        (quo)
    );

    // Quotient lies in (0.5, 2): without the integer bit, shift left one and drop the exponent.
    assign exp_n = quo[QUO_BITS-1] ? exp_q : exp_q - 7'sd1;
    assign man_n = quo[QUO_BITS-1] ? quo[MAN_W:1] : quo[MAN_W-1:0];

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        sign_d       = sign_q;
        exp_d        = exp_q;
        res_dat_d    = res_dat_q;
        res_id_d     = res_id_q;
        ovf_d        = ovf_q;
        unf_d        = unf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    last_grant_d = gnt1;
                    res_id_d     = gnt1;
                    sign_d       = op_sign;
                    exp_d        = exp_diff;
                    if (sp_hit) begin
                        res_dat_d = sp_res;
                        ovf_d     = sp_ovf;
                        unf_d     = sp_unf;
                        state_d   = DONE;
                    end else begin
                        state_d   = DIV;
                    end
                end
            end
            DIV: begin
                if (div_done) state_d = NORM;
            end
            NORM: begin
                state_d = DONE;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                if (exp_n >= 7'sd31) begin
                    res_dat_d = {sign_q, EXP_INF, {MAN_W{1'b0}}};
                    ovf_d     = 1'b1;
                end else if (exp_n <= 7'sd0) begin
                    res_dat_d = {sign_q, {(EXP_W + MAN_W){1'b0}}};
                    unf_d     = 1'b1;
                end else begin
                    res_dat_d = {sign_q, exp_n[EXP_W-1:0], man_n};
                end
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            sign_q       <= 1'b0;
            exp_q        <= '0;
            res_dat_q    <= '0;
            res_id_q     <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            sign_q       <= sign_d;
            exp_q        <= exp_d;
            res_dat_q    <= res_dat_d;
            res_id_q     <= res_id_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
        end
    end

    assign res_valid = (state_q == DONE);
    assign res_d     = res_dat_q;
    assign res_id    = res_id_q;
    assign res_ovf   = ovf_q;
    assign res_unf   = unf_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/fp16_div_sched.md
FP16_DIV_SCHED -- requirements
Module: fp16_div_sched

Interface
REQ-001 The block SHALL have a single clock `clk`. Reset `reset` SHALL be synchronous and active-high.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, clock
- reset, in, 1, sync active-high reset
- req0_valid, in, 1, requester 0 operand pair valid
- req0_ready, out, 1, requester 0 accept
- req0_a, in, 16, requester 0 dividend, IEEE half
- req0_b, in, 16, requester 0 divisor, IEEE half
- req1_valid / req1_ready / req1_a / req1_b, same as requester 0
- res_valid, out, 1, result valid
- res_ready, in, 1, result accept
- res_d, out, 16, quotient, IEEE half
- res_id, out, 1, index of the served requester
- res_ovf, out, 1, exponent overflow
- res_unf, out, 1, exponent underflow
- busy, out, 1, not IDLE
REQ-003 Parameters: none; all widths come from the package.

Function
REQ-004 The FSM SHALL have four states: IDLE, DIV, NORM, DONE.
REQ-005 In IDLE, `reqN_ready` SHALL assert combinationally only for the granted valid requester; the transfer occurs on an edge where `reqN_valid` and `reqN_ready` are both high.
REQ-006 Round-robin arbitration:
- If both requesters are valid, the grant SHALL go to the one not served last.
- `last_grant` SHALL reset to 1, so requester 0 wins first.
- `last_grant` SHALL update on every accept.
REQ-007 On accept, the block SHALL latch:
- sign = a[15]^b[15]
- exp_diff = a[14:10] - b[14:10] + 15, as 7-bit signed
- mantissas {1,a[9:0]} and {1,b[9:0]}
- `res_id`
REQ-008 DIV SHALL run a restoring division for exactly 12 cycles, producing q[11:0] (q[11] integer bit, q[10:0] fraction), with remainder discarded.
REQ-009 In NORM (1 cycle):
- If q[11]=1: mantissa = q[10:1], exp = exp_diff.
- Otherwise: mantissa = q[9:0], exp = exp_diff - 1.
- Rounding is truncation (toward zero).
REQ-010 Exponent range handling:
- exp ≥ 31: `res_d` = {sign,5'h1F,10'h0} and `res_ovf` = 1.
- exp ≤ 0: `res_d` = {sign,15'h0} and `res_unf` = 1.
REQ-011 Latency: `res_valid` SHALL rise on the 14th edge after the accepting edge (normal path).
REQ-012 In DONE:
- `res_valid` = 1, and `res_d`, `res_id` and flags SHALL be held stable until `res_valid` and `res_ready` are both high.
- On that edge the FSM SHALL return to IDLE.
- No new accept occurs in the same cycle as the result handoff.
REQ-013 `reqN_ready` SHALL be 0 in DIV, NORM and DONE; requests held during that time SHALL stay pending and unmodified.
REQ-014 `busy` SHALL be 1 whenever the state is not IDLE.

Reset
REQ-015 When `reset`=1 at an edge, regardless of state (including mid-DIV):
- the state SHALL become IDLE;
- res_valid, res_d, res_id, res_ovf and res_unf SHALL be 0;
- last_grant SHALL be 1;
- quotient and remainder registers SHALL be 0;
- any in-flight operation SHALL be dropped silently.
REQ-016 While `reset` is high, `req0_ready` and `req1_ready` SHALL be 0.

Configuration
REQ-017 Macro FP16_DIV_SPECIAL_EN, when defined:
- Operands with exponent field 0 or 31 SHALL bypass DIV/NORM and go to DONE on the edge after accept (latency 1).
- Priority: NaN operand, 0/0 or inf/inf gives 16'h7E00. Else x/0 or inf/x gives signed inf with `res_ovf`=1. Else 0/x or x/inf gives signed zero with `res_unf`=1.
- Exponent field 0 is treated as zero (subnormals flushed).
REQ-018 Macro FP16_DIV_SPECIAL_EN, when undefined: every operand SHALL take the normal path with the hidden bit forced to 1, with no special decoding.

Structure
REQ-019 Package fp16_div_pkg SHALL hold:
- EXP_W=5, MAN_W=10, BIAS=15, QUO_BITS=12
- the FSM state enum
- constants for the canonical NaN (16'h7E00) and the inf exponent.
REQ-020 Sub-module fp16_mant_div SHALL implement the 12-cycle restoring mantissa divider:
- inputs: start, dividend[10:0], divisor[10:0]
- outputs: done, q[11:0]
- The scheduler FSM drives it.

Verification
REQ-021 Single request, req0 a=16'h3C00, b=16'h4000 -> res_d=16'h3800, res_id=0, res_valid on the 14th edge after accept, no flags.
REQ-022 Truncation case, a=16'h3C00, b=16'h4200 (1/3) -> res_d=16'h3555.
REQ-023 Both requests valid in the same cycle:
- req0 16'h4000/16'h3C00 -> 16'h4000, id 0, served first.
- req1 16'hC000/16'h4000 -> 16'hBC00, id 1, served second.
- Then req0 again, confirming grant alternation.
REQ-024 Overflow case, a=16'h7BFF, b=16'h0400 (macro undefined) -> res_d=16'h7C00, res_ovf=1.
- Underflow case, a=16'h0400, b=16'h7BFF -> res_d=16'h0000, res_unf=1.
REQ-025 Special-value cases, a=16'h3C00, b=16'h0000:
- Macro defined -> 16'h7C00 with res_ovf=1, one edge after accept.
- Macro undefined -> 16'h7800 after 14 edges.
REQ-026 Reset and backpressure:
- Assert reset for 1 cycle at DIV cycle 5 -> IDLE and all outputs 0 on the next edge; a fresh request then completes correctly.
- Hold res_ready=0 for 10 cycles in DONE -> res_d stays stable and req ready stays 0.
